// File: rtl/coeff_block_packer_pkg.sv
// rtl/coeff_block_packer_pkg.sv - shared constants and FSM encoding for the coefficient block packer
package coeff_block_packer_pkg;

    localparam int BANKS             = 32;
    localparam int SUBBANKS_PER_BANK = 8;
    localparam int COEFF_BITS        = 50;
    localparam int COEFFS_PER_BLOCK  = 8;
    localparam int DEPTH_PER_SUBBANK = 1024;
    localparam int LINE_WIDTH        = COEFF_BITS * COEFFS_PER_BLOCK;
    localparam int AAW               = $clog2(DEPTH_PER_SUBBANK);
    localparam int BANK_W            = $clog2(BANKS);
    localparam int SUB_W             = $clog2(SUBBANKS_PER_BANK);
    localparam int POS_W             = $clog2(COEFFS_PER_BLOCK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/coeff_block_packer_if.sv
// rtl/coeff_block_packer_if.sv - control, coefficient stream and block-write bus of the packer
interface coeff_block_packer_if
    import coeff_block_packer_pkg::*;
    ();

    logic                   start;
    logic [AAW-1:0]         base_addr;
    logic                   busy;
    logic                   done;
    logic                   err_wrap;
    logic                   err_short;
    logic                   s_valid;
    logic                   s_ready;
    logic [COEFF_BITS-1:0]  s_coeff;
    logic                   s_last;
    logic                   m_valid;
    logic                   m_ready;
    logic [BANK_W-1:0]      m_bank;
    logic [SUB_W-1:0]       m_sub;
    logic [AAW-1:0]         m_addr;
    logic [LINE_WIDTH-1:0]  m_line;

    modport slave (
        input  start, base_addr, s_valid, s_coeff, s_last, m_ready,
        output busy, done, err_wrap, err_short, s_ready,
               m_valid, m_bank, m_sub, m_addr, m_line
    );

    modport master (
        output start, base_addr, s_valid, s_coeff, s_last, m_ready,
        input  busy, done, err_wrap, err_short, s_ready,
               m_valid, m_bank, m_sub, m_addr, m_line
    );

endinterface

// File: rtl/coeff_block_packer_block_addr_gen.sv
// rtl/coeff_block_packer_block_addr_gen.sv - block index to (bank, sub, addr) interleave counter
// Bank is the fastest digit, then sub-bank, then line address; carries replace division.
module coeff_block_packer_block_addr_gen
    import coeff_block_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init,
    input  logic [AAW-1:0]    i_base,
    input  logic              i_adv,
    output logic [BANK_W-1:0] o_bank,
    output logic [SUB_W-1:0]  o_sub,
    output logic [AAW-1:0]    o_addr,
    output logic              o_wrap
);

    logic [BANK_W-1:0] r_bank;
    logic [SUB_W-1:0]  r_sub;
    logic [AAW-1:0]    r_addr;
    logic              w_bank_c;
    logic              w_sub_c;

    assign w_bank_c = &r_bank;
    assign w_sub_c  = w_bank_c && (&r_sub);
    // The line address rolls past the top of the sub-bank on this advance.
    assign o_wrap   = i_adv && w_sub_c && (&r_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank <= '0;
            r_sub  <= '0;
            r_addr <= '0;
        end else if (i_init) begin
            r_bank <= '0;
            r_sub  <= '0;
            r_addr <= i_base;
        end else if (i_adv) begin
            r_bank <= r_bank + 1'b1;
            if (w_bank_c) r_sub  <= r_sub + 1'b1;
            if (w_sub_c)  r_addr <= r_addr + 1'b1;
        end
    end

    assign o_bank = r_bank;
    assign o_sub  = r_sub;
    assign o_addr = r_addr;

endmodule

// File: rtl/coeff_block_packer.sv
// rtl/coeff_block_packer.sv - packs 50-bit coefficients into 8-wide interleaved block writes
// Option PACKER_ZERO_PAD_EN: short final blocks are zero-filled and err_short is tied low.
module coeff_block_packer
    import coeff_block_packer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    coeff_block_packer_if.slave bus
);

    state_t                r_state;
    logic [POS_W-1:0]      r_pos;
    logic [LINE_WIDTH-1:0] r_asm;
    logic [LINE_WIDTH-1:0] r_m_line;
    logic [LINE_WIDTH-1:0] w_line;
    logic                  r_m_valid;
    logic [BANK_W-1:0]     r_m_bank;
    logic [SUB_W-1:0]      r_m_sub;
    logic [AAW-1:0]        r_m_addr;
    logic                  r_err_wrap;
`ifndef PACKER_ZERO_PAD_EN
    logic                  r_err_short;
`endif
    logic                  w_s_ready;
    logic                  w_s_fire;
    logic                  w_m_fire;
    logic                  w_last_pos;
    logic                  w_blk_end;
    logic                  w_gen_init;
    logic [BANK_W-1:0]     w_gen_bank;
    logic [SUB_W-1:0]      w_gen_sub;
    logic [AAW-1:0]        w_gen_addr;
    logic                  w_gen_wrap;

    assign w_s_ready  = (r_state == ST_FILL) && (!r_m_valid || bus.m_ready);
    assign w_s_fire   = bus.s_valid && w_s_ready;
    assign w_m_fire   = r_m_valid && bus.m_ready;
    assign w_last_pos = (r_pos == POS_W'(COEFFS_PER_BLOCK - 1));
    assign w_blk_end  = w_s_fire && (w_last_pos || bus.s_last);
    assign w_gen_init = (r_state == ST_IDLE) && bus.start;

    coeff_block_packer_block_addr_gen u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .i_init (w_gen_init),
        .i_base (bus.base_addr),
        .i_adv  (w_blk_end),
        .o_bank (w_gen_bank),
        .o_sub  (w_gen_sub),
        .o_addr (w_gen_addr),
        .o_wrap (w_gen_wrap)
    );

    // Assembly line with the incoming coefficient merged at the current position.
    always_comb begin
        w_line = r_asm;
        for (int p = 0; p < COEFFS_PER_BLOCK; p++) begin
            if (POS_W'(p) == r_pos) begin
                w_line[p*COEFF_BITS +: COEFF_BITS] = bus.s_coeff;
            end
`ifdef PACKER_ZERO_PAD_EN
            else if (POS_W'(p) > r_pos) begin
                w_line[p*COEFF_BITS +: COEFF_BITS] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pos       <= '0;
            r_asm       <= '0;
            r_m_line    <= '0;
            r_m_valid   <= 1'b0;
            r_m_bank    <= '0;
            r_m_sub     <= '0;
            r_m_addr    <= '0;
            r_err_wrap  <= 1'b0;
`ifndef PACKER_ZERO_PAD_EN
            r_err_short <= 1'b0;
`endif
        end else begin
            if (w_m_fire) r_m_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state     <= ST_FILL;
                        r_pos       <= '0;
                        r_err_wrap  <= 1'b0;
`ifndef PACKER_ZERO_PAD_EN
                        r_err_short <= 1'b0;
`endif
                    end
                end
                ST_FILL: begin
                    if (w_s_fire) begin
                        r_asm <= w_line;
                        r_pos <= r_pos + 1'b1;
                        // A load in the same cycle as a drain overrides the clear above.
                        if (w_blk_end) begin
                            r_pos     <= '0;
                            r_m_line  <= w_line;
                            r_m_bank  <= w_gen_bank;
                            r_m_sub   <= w_gen_sub;
                            r_m_addr  <= w_gen_addr;
                            r_m_valid <= 1'b1;
                            if (w_gen_wrap) r_err_wrap <= 1'b1;
                            if (bus.s_last) begin
                                r_state <= ST_DRAIN;
`ifndef PACKER_ZERO_PAD_EN
                                if (!w_last_pos) r_err_short <= 1'b1;
`endif
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_m_fire) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_ready  = w_s_ready;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = (r_state == ST_DRAIN) && w_m_fire;
    assign bus.m_valid  = r_m_valid;
    assign bus.m_bank   = r_m_bank;
    assign bus.m_sub    = r_m_sub;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_line   = r_m_line;
    assign bus.err_wrap = r_err_wrap;
`ifdef PACKER_ZERO_PAD_EN
    assign bus.err_short = 1'b0;
`else
    assign bus.err_short = r_err_short;
`endif

endmodule

// File: tb/tb_coeff_block_packer.sv
// tb/tb_coeff_block_packer.sv - directed table-driven bench for coeff_block_packer
module tb_coeff_block_packer;
    import coeff_block_packer_pkg::*;

    typedef struct {
        int n;      int base;  int mode;  int blk;
        int bank;   int sub;   int addr;  int nblk;  int wrap;
    } vec_t;

    typedef struct {
        logic [BANK_W-1:0]     bank;
        logic [SUB_W-1:0]      sub;
        logic [AAW-1:0]        addr;
        logic [LINE_WIDTH-1:0] line;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;
    int   done_cnt = 0;
    int   mon_errs = 0;
    wr_t  wq[$];
    vec_t vecs[8];

    coeff_block_packer_if bus();

    coeff_block_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // m_ready driver: held high, or toggled every cycle
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.m_ready = (rdy_mode == 1) ? ~bus.m_ready : 1'b1;
        end
    end

    // Monitor: records accepted writes, counts done, checks stall stability
    initial begin
        logic prev_stall;
        wr_t  prev;
        wr_t  cur;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                cur.bank = bus.m_bank; cur.sub = bus.m_sub;
                cur.addr = bus.m_addr; cur.line = bus.m_line;
                if (prev_stall && (!bus.m_valid || cur.bank !== prev.bank || cur.sub !== prev.sub ||
                                   cur.addr !== prev.addr || cur.line !== prev.line))
                    mon_errs++;
                if (bus.s_ready && bus.m_valid && !bus.m_ready) mon_errs++;
                if (bus.m_valid && bus.m_ready) wq.push_back(cur);
                if (bus.done) done_cnt++;
                prev_stall = bus.m_valid && !bus.m_ready;
                prev = cur;
            end
        end
    end

    task automatic do_start(input int base);
        bus.start = 1'b1;
        bus.base_addr = AAW'(base);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_coeffs(input int n, input int first, input bit with_last, output int cyc);
        int i;
        logic fire;
        i = 0; cyc = 0;
        while (i < n && cyc < 3 * n + 100) begin
            bus.s_valid = 1'b1;
            bus.s_coeff = COEFF_BITS'(first + i);
            bus.s_last  = with_last && (i == n - 1);
            @(negedge clk);
            fire = bus.s_ready;
            @(posedge clk); #1;
            if (fire) i++;
            cyc++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("send_timeout", 64'(i), 64'(n));
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_timeout", 64'(bus.busy), 64'd0);
    endtask

    task automatic run_row(input int r);
        vec_t v;
        int qb, db, eb, cyc, got;
        bit ok;
        v  = vecs[r];
        qb = wq.size(); db = done_cnt; eb = mon_errs;
        rdy_mode = v.mode;
        do_start(v.base);
        send_coeffs(v.n, 0, 1'b1, cyc);
        wait_done();
        rdy_mode = 0;
        if (v.mode == 0) chk($sformatf("r%0d_cycles", r), 64'(cyc), 64'(v.n));
        got = wq.size() - qb;
        chk($sformatf("r%0d_nblk", r), 64'(got), 64'(v.nblk));
        if (got > v.blk) begin
            chk($sformatf("r%0d_bank", r), 64'(wq[qb+v.blk].bank), 64'(v.bank));
            chk($sformatf("r%0d_sub", r),  64'(wq[qb+v.blk].sub),  64'(v.sub));
            chk($sformatf("r%0d_addr", r), 64'(wq[qb+v.blk].addr), 64'(v.addr));
        end else begin
            chk($sformatf("r%0d_blk_present", r), 64'(got), 64'(v.blk + 1));
        end
        ok = 1'b1;
        for (int b = 0; b < got; b++)
            for (int p = 0; p < COEFFS_PER_BLOCK; p++)
                if (wq[qb+b].line[p*COEFF_BITS +: COEFF_BITS] !== COEFF_BITS'(b * COEFFS_PER_BLOCK + p))
                    ok = 1'b0;
        chk($sformatf("r%0d_lines", r), 64'(ok), 64'd1);
        chk($sformatf("r%0d_done", r), 64'(done_cnt - db), 64'd1);
        chk($sformatf("r%0d_stall", r), 64'(mon_errs - eb), 64'd0);
        chk($sformatf("r%0d_busy", r), 64'(bus.busy), 64'd0);
        chk($sformatf("r%0d_err_wrap", r), 64'(bus.err_wrap), 64'(v.wrap));
        chk($sformatf("r%0d_err_short", r), 64'(bus.err_short), 64'd0);
    endtask

    initial begin
        int qb, cyc;
        logic [LINE_WIDTH-1:0] ln;
        bit ok;
        bus.start = 1'b0; bus.base_addr = '0; bus.s_valid = 1'b0;
        bus.s_coeff = '0; bus.s_last = 1'b0;
        //          n     base  mode blk  bank sub addr  nblk wrap
        vecs[0] = '{16,   0,    0,   0,   0,   0,  0,    2,   0};
        vecs[1] = '{16,   0,    0,   1,   1,   0,  0,    2,   0};
        vecs[2] = '{2056, 5,    0,   256, 0,   0,  6,    257, 0};
        vecs[3] = '{2056, 5,    0,   31,  31,  0,  5,    257, 0};
        vecs[4] = '{2056, 5,    0,   32,  0,   1,  5,    257, 0};
        vecs[5] = '{24,   0,    1,   2,   2,   0,  0,    3,   0};
        vecs[6] = '{4096, 1023, 0,   255, 31,  7,  1023, 512, 1};
        vecs[7] = '{4096, 1023, 0,   256, 0,   0,  0,    512, 1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_err_wrap", 64'(bus.err_wrap), 64'd0);
        chk("rst_err_short", 64'(bus.err_short), 64'd0);
        chk("rst_m_line_nz", 64'(|bus.m_line), 64'd0);
        chk("rst_m_dest", 64'({bus.m_bank, bus.m_sub, bus.m_addr}), 64'd0);

        for (int r = 0; r < 8; r++) run_row(r);

        // Short final block; its start also clears the wrap error left by the last row
        qb = wq.size();
        do_start(0);
        chk("start_clears_wrap", 64'(bus.err_wrap), 64'd0);
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        send_coeffs(3, 'h300, 1'b1, cyc);
        wait_done();
        if (wq.size() > qb) begin
            ln = wq[qb].line;
            chk("short_c0", 64'(ln[49:0]), 64'h300);
            chk("short_c2", 64'(ln[149:100]), 64'h302);
`ifdef PACKER_ZERO_PAD_EN
            chk("short_pad_zero", 64'(|ln[399:150]), 64'd0);
            chk("short_err", 64'(bus.err_short), 64'd0);
`else
            chk("short_err", 64'(bus.err_short), 64'd1);
`endif
        end else begin
            chk("short_blk_present", 64'(wq.size() - qb), 64'd1);
        end
        do_start(0);
        chk("start_clears_short", 64'(bus.err_short), 64'd0);
        send_coeffs(8, 0, 1'b1, cyc);
        wait_done();

        // Reset mid-block, then a clean transfer with an ignored start while busy
        qb = wq.size();
        do_start(0);
        send_coeffs(5, 'h100, 1'b0, cyc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_no_write", 64'(wq.size() - qb), 64'd0);
        do_start(0);
        send_coeffs(4, 'h200, 1'b0, cyc);
        do_start(9);
        send_coeffs(4, 'h204, 1'b1, cyc);
        chk("latency_m_valid", 64'(bus.m_valid), 64'd1);
        wait_done();
        chk("post_rst_nblk", 64'(wq.size() - qb), 64'd1);
        if (wq.size() > qb) begin
            chk("post_rst_dest", 64'({wq[qb].bank, wq[qb].sub, wq[qb].addr}), 64'd0);
            ok = 1'b1;
            for (int p = 0; p < COEFFS_PER_BLOCK; p++)
                if (wq[qb].line[p*COEFF_BITS +: COEFF_BITS] !== COEFF_BITS'('h200 + p)) ok = 1'b0;
            chk("post_rst_line", 64'(ok), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
